regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (we/waddr/wdata) between N_REQ writeback
//   sources: req 0 is the in-order pipeline WB stage; reqs 1..N_REQ-1 are multi-cycle
//   units (divider, load-miss return, ...).
//   Valid/ready handshake per requester. Req 0 is favoured; the others are served
//   round-robin. A starvation counter guarantees forward progress.
//   The write drive to the register file is registered (1-cycle latency).
// PARAMETERS
//   N_REQ       3   number of requesters, >= 2
//   STARVE_MAX  4   wait cycles after which a blocked req 1..N_REQ-1 overrides req 0, >= 1
//   AW          5   register address width
//   DW          32  write data width
// PORTS
//   clk_i       in   1         single clock, rising edge
//   rst_i       in   1         synchronous reset, active-high
//   req_valid_i in   N_REQ     requester i has a write pending
//   req_addr_i  in   N_REQ*AW  dest reg of requester i, bits [i*AW +: AW]
//   req_data_i  in   N_REQ*DW  write data of requester i, bits [i*DW +: DW]
//   req_ready_o out  N_REQ     one-hot grant, combinational; transfer = valid & ready
//   rf_we_o     out  1         register file write enable (registered)
//   rf_waddr_o  out  AW        register file write address (registered)
//   rf_wdata_o  out  DW        register file write data (registered)
//   grant_id_o  out  clog2(N)  index of last granted requester (registered, debug)
// BEHAVIOUR
//   Reset (rst_i=1 at clk edge):
//     - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, grant_id_o=0.
//     - rr_ptr=1; all wait counters=0.
//     - req_ready_o forced to 0 while rst_i=1.
//     - A write already in the output register is dropped. No partial state survives.
//   Handshake rules:
//     - Once valid, a requester holds valid/addr/data stable until ready.
//     - valid never retracts.
//     - At most one req_ready_o bit is high per cycle; it is only high where valid=1.
//   Grant priority (combinational, evaluated every cycle):
//     1. Any req i>=1 with valid and wait_cnt[i]==STARVE_MAX: lowest such index wins.
//     2. Else, if req_valid_i[0]: req 0 wins.
//     3. Else, round-robin over 1..N_REQ-1: first valid index starting at rr_ptr, wrapping
//        N_REQ-1 -> 1.
//     4. No valid requester: no grant.
//   rr_ptr:
//     - On any grant to i>=1 (via rule 1 or rule 3): rr_ptr <= (i==N_REQ-1) ? 1 : i+1.
//     - Unchanged on a grant to req 0 or no grant.
//   wait_cnt[i], i>=1:
//     - +1 (saturating at STARVE_MAX) when valid & !ready.
//     - Cleared to 0 on grant or when !valid.
//   Output register, on grant of i:
//     - rf_we_o   <= (req_addr_i[i] != 0)  (writes to r0 are accepted but suppressed).
//     - rf_waddr_o <= addr, rf_wdata_o <= data, grant_id_o <= i.
//     - No grant: rf_we_o <= 0; addr/data/grant_id hold their previous values.
//   Throughput and latency:
//     - Grant in cycle t -> rf_we_o high in cycle t+1; register file updated at end of t+1.
//     - Throughput is 1 write/cycle; back-to-back grants are allowed.
//   Same register written by two sources in consecutive grants:
//     - Written in grant order; the later grant's value is final.
//   Req 0 blocked by starvation override:
//     - The pipeline sees ready=0 and stalls.
//     - Req 0 may be blocked at most (N_REQ-1) consecutive cycles by rule-1 grants.
// TESTING
//   - Reset: hold rst_i 2 cycles with all valid=1 -> ready=0, rf_we_o=0, waddr=0, wdata=0.
//   - Single write: req0 valid, addr=5, data=0xDEADBEEF -> ready[0]=1 same cycle; next
//     cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF, grant_id=0.
//   - r0 suppression: req1 valid, addr=0, data=0x1234 -> ready[1]=1; next cycle rf_we_o=0.
//   - Round-robin: req0 idle, req1 & req2 valid continuously -> grants alternate 1,2,1,2;
//     rf_we_o=1 every cycle.
//   - Starvation: req0 valid every cycle, req2 valid from t0 -> req2 granted at t0+4
//     (STARVE_MAX=4), req0 ready=0 that cycle only, wait_cnt[2] returns to 0.
//   - Reset mid-operation: assert rst_i the cycle after a grant -> rf_we_o=0 next cycle,
//     rr_ptr=1, and after release req1 is served before req2 when both are valid.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between N_REQ writeback sources.
// Req 0 (pipeline WB) is favoured, others are round-robin, with starvation override.
module regfile_wb_arbiter #(
  parameter int N_REQ      = 3,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 5,
  parameter int DW         = 32,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*AW-1:0] req_addr_i,
  input  logic [N_REQ*DW-1:0] req_data_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic                rf_we_o,
  output logic [AW-1:0]       rf_waddr_o,
  output logic [DW-1:0]       rf_wdata_o,
  output logic [IDW-1:0]      grant_id_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  wait_cnt [1:N_REQ-1];

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [N_REQ-1:0] grant_oh;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_data;

  always_comb begin : grant_logic
    logic           starve_hit;
    logic           rr_hit;
    logic [IDW-1:0] starve_idx;
    logic [IDW-1:0] rr_idx;
    int             rr_base;
    int             cand;
    // NOTE: every variable gets a default before any condition, so no latch is inferred.
    starve_hit = 1'b0;
    starve_idx = '0;
    rr_hit     = 1'b0;
    rr_idx     = '0;
    rr_base    = int'(rr_ptr) - 1;
    cand       = 0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_oh   = '0;
    sel_addr   = '0;
    sel_data   = '0;

    // Descending scans so the lowest index / nearest-to-rr_ptr candidate is written last.
    for (int i = N_REQ - 1; i >= 1; i--) begin
      if (req_valid_i[i] && wait_cnt[i] == CW'(STARVE_MAX)) begin
        starve_hit = 1'b1;
        starve_idx = IDW'(i);
      end
    end
    for (int k = N_REQ - 2; k >= 0; k--) begin
      cand = 1 + ((rr_base + k) % (N_REQ - 1));
      if (req_valid_i[cand]) begin
        rr_hit = 1'b1;
        rr_idx = IDW'(cand);
      end
    end

    if (!rst_i) begin
      if (starve_hit) begin
        grant_vld = 1'b1;
        grant_idx = starve_idx;
      end else if (req_valid_i[0]) begin
        grant_vld = 1'b1;
        grant_idx = '0;
      end else if (rr_hit) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (grant_vld && grant_idx == IDW'(i)) begin
        grant_oh[i] = 1'b1;
        sel_addr    = req_addr_i[i*AW +: AW];
        sel_data    = req_data_i[i*DW +: DW];
      end
    end
  end

  assign req_ready_o = grant_oh;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      grant_id_o <= '0;
      rr_ptr     <= IDW'(1);
      // NOTE: the wait counters are a tiny array of control state, so they are reset too.
      for (int i = 1; i < N_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      rf_we_o <= grant_vld && (sel_addr != '0);
      if (grant_vld) begin
        rf_waddr_o <= sel_addr;
        rf_wdata_o <= sel_data;
        grant_id_o <= grant_idx;
        if (grant_idx != '0) begin
          rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? IDW'(1) : grant_idx + IDW'(1);
        end
      end
      for (int i = 1; i < N_REQ; i++) begin
        if (!req_valid_i[i] || grant_oh[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CW'(STARVE_MAX)) begin
          wait_cnt[i] <= wait_cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed literal cases plus randomized
// requester traffic compared every cycle against a rule-level behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N_REQ      = 3;
  localparam int STARVE_MAX = 4;
  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int IDW        = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ*AW-1:0] req_addr_i;
  logic [N_REQ*DW-1:0] req_data_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic                rf_we_o;
  logic [AW-1:0]       rf_waddr_o;
  logic [DW-1:0]       rf_wdata_o;
  logic [IDW-1:0]      grant_id_o;

  regfile_wb_arbiter #(
    .N_REQ(N_REQ), .STARVE_MAX(STARVE_MAX), .AW(AW), .DW(DW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .grant_id_o(grant_id_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               model_live = 1'b0;
  int               m_rr;
  int               m_wait [N_REQ];
  logic             m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  int               m_gid;
  logic [N_REQ-1:0] xfer_q = '0;

  function automatic int model_pick(input logic [N_REQ-1:0] v);
    for (int i = 1; i < N_REQ; i++)
      if (v[i] && m_wait[i] >= STARVE_MAX) return i;
    if (v[0]) return 0;
    for (int k = 0; k < N_REQ - 1; k++) begin
      int i;
      i = 1 + (m_rr - 1 + k) % (N_REQ - 1);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk_i) begin
    int g;
    logic [N_REQ-1:0] exp_rdy;
    if (model_live) begin
      check("model rf_we", rf_we_o, m_we);
      check("model rf_waddr", rf_waddr_o, m_addr);
      check("model rf_wdata", rf_wdata_o, m_data);
      check("model grant_id", grant_id_o, m_gid);
    end
    g = (rst_i === 1'b1) ? -1 : model_pick(req_valid_i);
    exp_rdy = (g < 0) ? '0 : (N_REQ'(1) << g);
    if (model_live || rst_i === 1'b1) check("model ready", req_ready_o, exp_rdy);
    xfer_q = req_valid_i & req_ready_o;

    if (rst_i === 1'b1) begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_gid = 0; m_rr = 1;
      for (int i = 0; i < N_REQ; i++) m_wait[i] = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (g >= 0) begin
        m_addr = req_addr_i[g*AW +: AW];
        m_data = req_data_i[g*DW +: DW];
        m_we   = (m_addr != '0);
        m_gid  = g;
        if (g >= 1) m_rr = (g == N_REQ - 1) ? 1 : g + 1;
      end else begin
        m_we = 1'b0;
      end
      for (int i = 1; i < N_REQ; i++) begin
        if (!req_valid_i[i] || g == i) m_wait[i] = 0;
        else m_wait[i] = (m_wait[i] < STARVE_MAX) ? m_wait[i] + 1 : STARVE_MAX;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_i[i]         = v;
    req_addr_i[i*AW +: AW] = a;
    req_data_i[i*DW +: DW] = d;
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '1;
    req_addr_i  = '1;
    req_data_i  = '1;

    // Reset held two cycles with every requester valid
    for (int c = 0; c < 2; c++) begin
      step();
      check("reset ready", req_ready_o, 0);
      check("reset we", rf_we_o, 0);
      check("reset waddr", rf_waddr_o, 0);
      check("reset wdata", rf_wdata_o, 0);
      check("reset gid", grant_id_o, 0);
    end
    req_valid_i = '0;
    step();
    rst_i = 1'b0;

    // Single write from req 0
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("single ready", req_ready_o, 3'b001);
    step();
    check("single we", rf_we_o, 1);
    check("single waddr", rf_waddr_o, 5);
    check("single wdata", rf_wdata_o, 32'hDEADBEEF);
    check("single gid", grant_id_o, 0);
    req_valid_i[0] = 1'b0;

    // Write to r0 is granted but suppressed; rr_ptr moves to 2
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1 check("r0 ready", req_ready_o, 3'b010);
    step();
    check("r0 we", rf_we_o, 0);
    check("r0 gid", grant_id_o, 1);
    check("r0 wdata", rf_wdata_o, 32'h1234);
    req_valid_i[1] = 1'b0;

    // Round-robin between req1 and req2, starting at 2 since req1 was served last
    set_req(1, 1'b1, 5'd7, 32'hA000_0000);
    set_req(2, 1'b1, 5'd9, 32'hB000_0000);
    for (int k = 0; k < 4; k++) begin
      int e;
      e = (k % 2 == 0) ? 2 : 1;
      #1 check("rr ready", req_ready_o, 3'b001 << e);
      step();
      check("rr we", rf_we_o, 1);
      check("rr gid", grant_id_o, e);
      check("rr waddr", rf_waddr_o, (e == 1) ? 7 : 9);
      req_data_i[e*DW +: DW] = req_data_i[e*DW +: DW] + 32'd1;
    end
    req_valid_i = '0;
    step();

    // Starvation: req0 always valid, req2 valid continuously; req2 wins at k=4 and k=9
    set_req(0, 1'b1, 5'd3, 32'h0000_0100);
    set_req(2, 1'b1, 5'd4, 32'h0000_0200);
    for (int k = 0; k < 10; k++) begin
      int e;
      e = (k == 4 || k == 9) ? 2 : 0;
      #1 check("starve ready", req_ready_o, 3'b001 << e);
      step();
      check("starve gid", grant_id_o, e);
      req_data_i[e*DW +: DW] = req_data_i[e*DW +: DW] + 32'd1;
    end
    req_valid_i = '0;
    step();

    // Reset the cycle after a grant to req1: rr_ptr back to 1, so req1 precedes req2
    set_req(1, 1'b1, 5'd11, 32'hCAFE_0001);
    #1 check("mid grant ready", req_ready_o, 3'b010);
    step();
    req_valid_i[1] = 1'b0;
    rst_i = 1'b1;
    check("mid we before rst", rf_we_o, 1);
    step();
    check("mid rst we", rf_we_o, 0);
    check("mid rst waddr", rf_waddr_o, 0);
    rst_i = 1'b0;
    set_req(1, 1'b1, 5'd12, 32'hCAFE_0002);
    set_req(2, 1'b1, 5'd13, 32'hCAFE_0003);
    #1 check("post rst first", req_ready_o, 3'b010);
    step();
    req_valid_i[1] = 1'b0;
    #1 check("post rst second", req_ready_o, 3'b100);
    step();
    req_valid_i = '0;
    step();

    // Randomized traffic, occasional resets; requesters obey the hold-until-ready rule
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid_i[i] || xfer_q[i]) begin
          if ($urandom_range(0, 99) < ((i == 0) ? 70 : 45)) begin
            req_valid_i[i]         = 1'b1;
            req_addr_i[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            req_data_i[i*DW +: DW] = $urandom;
          end else begin
            req_valid_i[i] = 1'b0;
          end
        end
      end
      step();
    end
    rst_i       = 1'b0;
    req_valid_i = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
